// File: rtl/flag_unit.sv
// Condition-flag register for the single-cycle datapath: derives Z/V/N from the
// retiring ALU operation, applies the per-opcode write mask, and freezes after HLT.
module flag_unit #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inst_valid,
   input  logic [3:0]    opcode,
   input  logic [DW-1:0] op_a,
   input  logic [DW-1:0] op_b,
   input  logic [DW-1:0] alu_out,
   output logic [2:0]    Flag,
   output logic [2:0]    flag_next,
   output logic          flag_upd,
   output logic          halted
);

   // inst_valid is a valid-only qualifier with no ready: this block always accepts,
   // and a cycle with inst_valid=0 is a bubble that changes nothing but clears flag_upd.

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic signed [DW:0] S_MAX = {2'b00, {(DW-1){1'b1}}};
   localparam logic signed [DW:0] S_MIN = {2'b11, {(DW-1){1'b0}}};

   state_t state;

   logic             upd;
   logic             wr_zvn;
   logic             wr_z;
   logic             z_new;
   logic             n_new;
   logic             v_new;
   logic signed [DW:0] sum_ext;
   logic signed [DW:0] dif_ext;

   assign upd    = inst_valid && (state == RUN);
   assign wr_zvn = (opcode == OP_ADD) || (opcode == OP_SUB);
   assign wr_z   = (opcode == OP_XOR) || (opcode == OP_SLL) ||
                   (opcode == OP_SRA) || (opcode == OP_ROR);

   // A DW-bit wrapped result has the wrong sign exactly when the exact sum leaves
   // the signed DW-bit range, so V is taken from a one-bit-wider exact result.
   assign sum_ext = $signed({op_a[DW-1], op_a}) + $signed({op_b[DW-1], op_b});
   assign dif_ext = $signed({op_a[DW-1], op_a}) - $signed({op_b[DW-1], op_b});

   assign z_new = (alu_out == '0);
   assign n_new = alu_out[DW-1];

   always_comb begin
      v_new = 1'b0;
      if (opcode == OP_SUB) begin
         v_new = (dif_ext > S_MAX) || (dif_ext < S_MIN);
      end else begin
         v_new = (sum_ext > S_MAX) || (sum_ext < S_MIN);
      end
   end

   always_comb begin
      flag_next = Flag;
      if (upd && wr_zvn) begin
         flag_next = {z_new, v_new, n_new};
      end else if (upd && wr_z) begin
         flag_next[2] = z_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         Flag     <= 3'b000;
         flag_upd <= 1'b0;
         halted   <= 1'b0;
      end else begin
         flag_upd <= upd && (wr_zvn || wr_z);
         if (upd) begin
            Flag <= flag_next;
         end
         case (state)
            RUN: begin
               if (upd && (opcode == OP_HLT)) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            HALTED: begin
               state  <= HALTED;
               halted <= 1'b1;
            end
            default: begin
               state  <= RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed scenarios plus randomized instructions checked
// against an integer-arithmetic model of the flag rules.
module tb_flag_unit;

   localparam int DW = 16;
   localparam logic [DW-1:0] MAXP = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MINN = {1'b1, {(DW-1){1'b0}}};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          inst_valid = 1'b0;
   logic [3:0]    opcode = 4'd0;
   logic [DW-1:0] op_a = '0;
   logic [DW-1:0] op_b = '0;
   logic [DW-1:0] alu_out = '0;
   logic [2:0]    Flag;
   logic [2:0]    flag_next;
   logic          flag_upd;
   logic          halted;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   flag_unit #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .opcode(opcode),
      .op_a(op_a), .op_b(op_b), .alu_out(alu_out),
      .Flag(Flag), .flag_next(flag_next), .flag_upd(flag_upd), .halted(halted)
   );

   // ---------------- reference model ----------------
   function automatic bit writes_flags(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
   endfunction

   function automatic int exact_result(input logic [3:0] op, input logic [DW-1:0] a, b);
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      return (op == 4'd1) ? sa - sb : sa + sb;
   endfunction

   function automatic logic [DW-1:0] saturate(input int res);
      logic [31:0] t;
      t = res;
      if (res > 2**(DW-1) - 1) return MAXP;
      if (res < -(2**(DW-1)))  return MINN;
      return t[DW-1:0];
   endfunction

   function automatic logic [2:0] ref_flags(input logic [2:0] cur, input logic [3:0] op,
                                            input logic [DW-1:0] a, b, r);
      logic [2:0] f;
      int res;
      f = cur;
      if (op inside {4'd0, 4'd1}) begin
         res  = exact_result(op, a, b);
         f[2] = (r == '0);
         f[1] = (res > 2**(DW-1) - 1) || (res < -(2**(DW-1)));
         f[0] = r[DW-1];
      end else if (op inside {4'd2, 4'd4, 4'd5, 4'd6}) begin
         f[2] = (r == '0);
      end
      return f;
   endfunction

   function automatic logic [DW-1:0] pick_operand();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return DW'(1);
         2: return MAXP;
         3: return MINN;
         4: return '1;
         default: return DW'($urandom);
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op,
                        input logic [DW-1:0] a, b, r);
      inst_valid = v;
      opcode     = op;
      op_a       = a;
      op_b       = b;
      alu_out    = r;
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      vectors++;
      if ({Flag, flag_upd, halted} !== 5'b00000) begin
         miscompares++;
         $display("FAIL reset_state: got %b expected %b", {Flag, flag_upd, halted}, 5'b00000);
      end
      drive(1'b1, 4'd0, 16'h8000, 16'h8000, 16'h8000);
      step();
      drive(1'b1, 4'd4, 16'h1234, 16'h0003, 16'h0000);
      step();
      vectors++;
      if (Flag !== 3'b111) begin
         miscompares++;
         $display("FAIL reset_preload: got %b expected %b", Flag, 3'b111);
      end
      #3 rst_n = 1'b0;
      #1;
      vectors++;
      if ({Flag, halted} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_async: got %b expected %b", {Flag, halted}, 4'b0000);
      end
      drive(1'b0, 4'd0, '0, '0, '0);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_add_overflow();
      drive(1'b1, 4'd0, 16'h7FFF, 16'h0001, 16'h7FFF);
      vectors++;
      if (flag_next !== 3'b010) begin
         miscompares++;
         $display("FAIL add_ovf_next: got %b expected %b", flag_next, 3'b010);
      end
      step();
      vectors++;
      if ({Flag, flag_upd} !== 4'b0101) begin
         miscompares++;
         $display("FAIL add_ovf: got %b expected %b", {Flag, flag_upd}, 4'b0101);
      end
   endtask

   task automatic test_sub_zero_xor();
      drive(1'b1, 4'd1, 16'h1234, 16'h1234, 16'h0000);
      step();
      vectors++;
      if (Flag !== 3'b100) begin
         miscompares++;
         $display("FAIL sub_zero: got %b expected %b", Flag, 3'b100);
      end
      drive(1'b1, 4'd2, 16'h8000, 16'h0001, 16'h8001);
      step();
      vectors++;
      if ({Flag, flag_upd} !== 4'b0001) begin
         miscompares++;
         $display("FAIL xor_z_only: got %b expected %b", {Flag, flag_upd}, 4'b0001);
      end
   endtask

   task automatic test_partial_mask();
      drive(1'b1, 4'd0, 16'h8000, 16'h8000, 16'h8000);
      step();
      vectors++;
      if (Flag !== 3'b011) begin
         miscompares++;
         $display("FAIL add_neg_ovf: got %b expected %b", Flag, 3'b011);
      end
      drive(1'b1, 4'd4, 16'h8000, 16'h0001, 16'h0000);
      step();
      vectors++;
      if (Flag !== 3'b111) begin
         miscompares++;
         $display("FAIL sll_hold_vn: got %b expected %b", Flag, 3'b111);
      end
      drive(1'b1, 4'd8, 16'h0000, 16'h0000, 16'h0000);
      step();
      vectors++;
      if ({Flag, flag_upd} !== 4'b1110) begin
         miscompares++;
         $display("FAIL lw_no_write: got %b expected %b", {Flag, flag_upd}, 4'b1110);
      end
   endtask

   task automatic test_bubble();
      drive(1'b0, 4'd0, 16'h0001, 16'hFFFF, 16'h0000);
      vectors++;
      if (flag_next !== 3'b111) begin
         miscompares++;
         $display("FAIL bubble_next: got %b expected %b", flag_next, 3'b111);
      end
      step();
      vectors++;
      if ({Flag, flag_upd} !== 4'b1110) begin
         miscompares++;
         $display("FAIL bubble_hold: got %b expected %b", {Flag, flag_upd}, 4'b1110);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 4'd1, 16'h8000, 16'h0001, 16'h8000);
      step();
      vectors++;
      if ({Flag, flag_upd} !== 4'b0111) begin
         miscompares++;
         $display("FAIL b2b_sub_ovf: got %b expected %b", {Flag, flag_upd}, 4'b0111);
      end
      drive(1'b1, 4'd1, 16'h8000, 16'h0001, 16'h8000);
      step();
      vectors++;
      if ({Flag, flag_upd} !== 4'b0111) begin
         miscompares++;
         $display("FAIL b2b_same_value: got %b expected %b", {Flag, flag_upd}, 4'b0111);
      end
      drive(1'b1, 4'd6, 16'h0000, 16'h0000, 16'h0000);
      step();
      vectors++;
      if ({Flag, flag_upd} !== 4'b1111) begin
         miscompares++;
         $display("FAIL b2b_ror: got %b expected %b", {Flag, flag_upd}, 4'b1111);
      end
   endtask

   task automatic test_halt();
      logic [2:0] held;
      held = Flag;
      drive(1'b1, 4'd15, 16'h0000, 16'h0000, 16'h0000);
      step();
      vectors++;
      if ({halted, Flag, flag_upd} !== {1'b1, held, 1'b0}) begin
         miscompares++;
         $display("FAIL halt_enter: got %b expected %b", {halted, Flag, flag_upd}, {1'b1, held, 1'b0});
      end
      drive(1'b1, 4'd0, 16'h0001, 16'hFFFF, 16'h0000);
      vectors++;
      if (flag_next !== held) begin
         miscompares++;
         $display("FAIL halt_next: got %b expected %b", flag_next, held);
      end
      step();
      vectors++;
      if ({halted, Flag, flag_upd} !== {1'b1, held, 1'b0}) begin
         miscompares++;
         $display("FAIL halt_frozen: got %b expected %b", {halted, Flag, flag_upd}, {1'b1, held, 1'b0});
      end
      #3 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      vectors++;
      if ({halted, Flag} !== 4'b0000) begin
         miscompares++;
         $display("FAIL halt_reset: got %b expected %b", {halted, Flag}, 4'b0000);
      end
      step();
      drive(1'b1, 4'd0, 16'h0001, 16'hFFFF, 16'h0000);
      step();
      vectors++;
      if ({halted, Flag, flag_upd} !== 5'b01001) begin
         miscompares++;
         $display("FAIL halt_resume: got %b expected %b", {halted, Flag, flag_upd}, 5'b01001);
      end
   endtask

   task automatic test_random();
      logic [2:0]    m_flag;
      logic [2:0]    exp;
      logic          v;
      logic [3:0]    op;
      logic [DW-1:0] a, b, r;
      m_flag = Flag;
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         op = 4'($urandom_range(0, 14));
         a  = pick_operand();
         b  = pick_operand();
         if (op inside {4'd0, 4'd1}) r = saturate(exact_result(op, a, b));
         else if ($urandom_range(0, 3) == 0) r = '0;
         else r = DW'($urandom);
         drive(v, op, a, b, r);
         exp = v ? ref_flags(m_flag, op, a, b, r) : m_flag;
         vectors++;
         if (flag_next !== exp) begin
            miscompares++;
            $display("FAIL rand_next[%0d]: got %b expected %b (op %h a %h b %h r %h)", i, flag_next, exp, op, a, b, r);
         end
         step();
         vectors++;
         if ({Flag, flag_upd, halted} !== {exp, v && writes_flags(op), 1'b0}) begin
            miscompares++;
            $display("FAIL rand_edge[%0d]: got %b expected %b", i, {Flag, flag_upd, halted}, {exp, v && writes_flags(op), 1'b0});
         end
         m_flag = exp;
      end
   endtask

   initial begin
      #12 rst_n = 1'b1;
      step();
      test_reset();
      test_add_overflow();
      test_sub_zero_xor();
      test_partial_mask();
      test_bubble();
      test_back_to_back();
      test_halt();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
